// File: rtl/soc_nios_div_pkg.sv
// rtl/soc_nios_div_pkg.sv - shared types, widths and sign helper for the div cell
package soc_nios_div_pkg;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_CNT_W  = $clog2(DIV_DATA_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Two's-complement negate when neg=1; doubles as abs() on a sign bit.
    function automatic logic [DIV_DATA_W-1:0] div_cond_neg(
        input logic [DIV_DATA_W-1:0] v,
        input logic                  neg
    );
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/soc_nios_div_step.sv
// rtl/soc_nios_div_step.sv - one combinational restoring-division step
module soc_nios_div_step
    import soc_nios_div_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic [DATA_W:0]   rem,
    input  logic              next_bit,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W:0]   rem_next,
    output logic              quo_bit
);

    logic [DATA_W+1:0] shifted;
    logic [DATA_W+1:0] diff;

    // rem < divisor on entry, so shifted < 2*divisor and the top diff bit is a true borrow.
    always_comb begin
        shifted  = {rem, next_bit};
        diff     = shifted - {2'b00, divisor};
        quo_bit  = ~diff[DATA_W+1];
        rem_next = quo_bit ? diff[DATA_W:0] : shifted[DATA_W:0];
    end

endmodule

// File: rtl/soc_nios_div_cell.sv
// rtl/soc_nios_div_cell.sv - iterative radix-2 restoring divider for the Nios M stage
module soc_nios_div_cell
    import soc_nios_div_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] M_div_src1,
    input  logic [DATA_W-1:0] M_div_src2,
    input  logic              M_div_signed,
    input  logic              M_div_start,
    input  logic              M_div_kill,
    output logic              M_div_busy,
    output logic              M_div_done,
    output logic [DATA_W-1:0] M_div_quotient,
    output logic [DATA_W-1:0] M_div_remainder
);

    div_state_e             state;
    logic [DIV_CNT_W-1:0]   cnt;
    logic [DATA_W:0]        rem;
    logic [DATA_W-1:0]      quo;
    logic [DATA_W-1:0]      dvsr;
    logic [DATA_W-1:0]      dvnd_orig;
    logic                   q_neg;
    logic                   r_neg;
    logic                   dvsr_zero;

    logic                   s1;
    logic                   s2;
    logic [DATA_W-1:0]      mag1;
    logic [DATA_W-1:0]      mag2;
    logic [DATA_W:0]        step_rem;
    logic                   step_qbit;

    always_comb begin
        s1   = M_div_signed & M_div_src1[DATA_W-1];
        s2   = M_div_signed & M_div_src2[DATA_W-1];
        mag1 = div_cond_neg(M_div_src1, s1);
        mag2 = div_cond_neg(M_div_src2, s2);
    end

    // quo shifts the dividend out from the top while quotient bits enter at the bottom.
    soc_nios_div_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .rem      (rem),
        .next_bit (quo[DATA_W-1]),
        .divisor  (dvsr),
        .rem_next (step_rem),
        .quo_bit  (step_qbit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            rem             <= '0;
            quo             <= '0;
            dvsr            <= '0;
            dvnd_orig       <= '0;
            q_neg           <= 1'b0;
            r_neg           <= 1'b0;
            dvsr_zero       <= 1'b0;
            M_div_busy      <= 1'b0;
            M_div_done      <= 1'b0;
            M_div_quotient  <= '0;
            M_div_remainder <= '0;
        end else begin
            case (state)
                IDLE: begin
                    M_div_done <= 1'b0;
                    if (M_div_start && !M_div_kill) begin
                        rem        <= '0;
                        quo        <= mag1;
                        dvsr       <= mag2;
                        dvnd_orig  <= M_div_src1;
                        q_neg      <= s1 ^ s2;
                        r_neg      <= s1;
                        dvsr_zero  <= (M_div_src2 == '0);
                        cnt        <= DIV_CNT_W'(DATA_W - 1);
                        M_div_busy <= 1'b1;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    if (M_div_kill) begin
                        M_div_busy <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        rem <= step_rem;
                        quo <= {quo[DATA_W-2:0], step_qbit};
                        if (cnt == '0) begin
                            state <= FIX;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                FIX: begin
                    M_div_busy <= 1'b0;
                    if (M_div_kill) begin
                        state <= IDLE;
                    end else begin
                        if (dvsr_zero) begin
                            M_div_quotient  <= '1;
                            M_div_remainder <= dvnd_orig;
                        end else begin
                            M_div_quotient  <= div_cond_neg(quo, q_neg);
                            M_div_remainder <= div_cond_neg(rem[DATA_W-1:0], r_neg);
                        end
                        M_div_done <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    M_div_done <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    M_div_busy <= 1'b0;
                    M_div_done <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soc_nios_div_cell.sv
// tb/tb_soc_nios_div_cell.sv - directed self-checking bench for soc_nios_div_cell
module tb_soc_nios_div_cell;

    logic        clk;
    logic        reset;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        sgn;
    logic        start;
    logic        kill;
    logic        busy;
    logic        done;
    logic [31:0] quo;
    logic [31:0] rem;

    int n_checks = 0;
    int n_errors = 0;

    soc_nios_div_cell #(
        .DATA_W (32)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .M_div_src1      (src1),
        .M_div_src2      (src2),
        .M_div_signed    (sgn),
        .M_div_start     (start),
        .M_div_kill      (kill),
        .M_div_busy      (busy),
        .M_div_done      (done),
        .M_div_quotient  (quo),
        .M_div_remainder (rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; start is driven in that cycle (cycle 0).
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] exp_q, input logic [31:0] exp_r);
        int done_cyc = 0;
        int busy_cnt = 0;
        src1  = a;
        src2  = b;
        sgn   = s;
        start = 1'b1;
        for (int k = 1; k <= 60 && done_cyc == 0; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cnt++;
            if (done) done_cyc = k;
        end
        check_eq({tag, "_latency"}, 32'(done_cyc), 32'd34);
        check_eq({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
        check_eq({tag, "_q"}, quo, exp_q);
        check_eq({tag, "_r"}, rem, exp_r);
        @(negedge clk);
        check_eq({tag, "_done_single"}, 32'(done), 32'd0);
    endtask

    initial begin
        int seen_done;
        reset = 1'b1;
        src1  = '0;
        src2  = '0;
        sgn   = 1'b0;
        start = 1'b0;
        kill  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_q", quo, 32'd0);
        check_eq("reset_r", rem, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // back-to-back: each run_op returns in the first IDLE cycle after done
        run_op("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
        run_op("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0);
        run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_op("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1);
        run_op("u_fff9_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1);
        run_op("u_div0", 32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678);
        run_op("s_m5_div0", 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
        run_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
        run_op("u_ovf_ops", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000);

        // kill mid-operation; start at cycle 5 must be ignored
        seen_done = 0;
        src1  = 32'd100;
        src2  = 32'd7;
        sgn   = 1'b0;
        start = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            start = 1'b0;
            kill  = 1'b0;
            if (done) seen_done = 1;
            if (c == 5) begin
                src1  = 32'd9;
                src2  = 32'd3;
                start = 1'b1;
            end
            if (c == 10) kill = 1'b1;
        end
        check_eq("kill_busy_low", 32'(busy), 32'd0);
        check_eq("kill_no_done", 32'(seen_done), 32'd0);
        check_eq("kill_q_held", quo, 32'd0);
        check_eq("kill_r_held", rem, 32'h8000_0000);
        @(negedge clk);
        run_op("after_kill_9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0);

        // reset in the middle of an operation
        seen_done = 0;
        src1  = 32'd100;
        src2  = 32'd7;
        sgn   = 1'b0;
        start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) seen_done = 1;
            if (c == 20) reset = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_done", 32'(done), 32'd0);
        check_eq("midrst_q", quo, 32'd0);
        check_eq("midrst_r", rem, 32'd0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        check_eq("midrst_no_done", 32'(seen_done), 32'd0);
        run_op("post_rst_1000_10", 32'd1000, 32'd10, 1'b0, 32'd100, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
